// File: rtl/imem_loader.sv
// imem_loader: writable 64-word instruction memory with a byte-stream loader.
//
// Programs are streamed in at run time as a length byte followed by
// little-endian words (first byte lands in bits [7:0]). While the loader is
// busy, cpu_hold is high so the processor stays in reset. The fetch stage
// reads through the same zero-latency combinational port as before.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a one-byte XOR
// checksum after the data bytes. A mismatch raises the sticky err flag and
// suppresses the done pulse. Without the macro there is no checksum byte and
// err is tied low.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       synchronous active-low reset (0 = reset); restarts the clear
//   addr        fetch read address
//   q           RAM[addr], combinational
//   start       pulse; begins a load when idle, ignored otherwise
//   byte_in     stream data byte
//   byte_valid  byte_in valid
//   byte_ready  loader accepts a byte this cycle (independent of byte_valid)
//   cpu_hold    high whenever the loader is not idle
//   done        one-cycle pulse after a successful load
//   err         sticky checksum error
//   word_count  words written in the current/last load

module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   addr,
    output logic [N-1:0] q,
    input  logic         start,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         cpu_hold,
    output logic         done,
    output logic         err,
    output logic [6:0]   word_count
);

    localparam int LANES = N / 8;
    localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN,
        LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    mem [DEPTH];

    logic [5:0]      clr;
    logic            from_start;   // CLEAR was entered via start, continue to LEN
    logic [6:0]      len;
    logic [5:0]      wptr;
    logic [BW-1:0]   bidx;
    logic [N-1:0]    asm_r;
    logic [N-1:0]    asm_nxt;
    logic [6:0]      wc;
    logic            err_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    logic            xfer;
    logic            word_last;
    logic            last_word;
    logic            mem_we;
    logic [5:0]      mem_wa;
    logic [N-1:0]    mem_wd;

    assign xfer      = byte_valid & byte_ready;
    assign word_last = (bidx == BW'(LANES - 1));
    assign last_word = ((wc + 7'd1) == len);

    // Assembly register with the current byte dropped into its lane; on the
    // final lane this is the complete word written to memory on the same edge.
    always_comb begin
        asm_nxt = asm_r;
        asm_nxt[8*int'(bidx) +: 8] = byte_in;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (!reset) begin
            state_nxt = CLEAR;
        end else begin
            case (state)
                IDLE:  if (start) state_nxt = CLEAR;
                CLEAR: if (clr == 6'(DEPTH - 1)) state_nxt = from_start ? LEN : IDLE;
                LEN:   if (xfer) state_nxt = LOAD;
                LOAD: begin
                    if (xfer && word_last && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK:   if (xfer) state_nxt = (byte_in == csum) ? DONE : IDLE;
`endif
                DONE:  state_nxt = IDLE;
                default: state_nxt = CLEAR;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        byte_ready = 1'b0;
        cpu_hold   = (state != IDLE);
        done       = (state == DONE);
        case (state)
            LEN, LOAD: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:       byte_ready = 1'b1;
`endif
            default:   byte_ready = 1'b0;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif
    assign word_count = wc;

    // ---------------- memory write port ----------------
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wptr;
        mem_wd = asm_nxt;
        if (reset) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr;
                mem_wd = '0;
            end else if (state == LOAD && xfer && word_last) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign q = mem[addr];

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            clr        <= '0;
            from_start <= 1'b0;
            len        <= '0;
            wptr       <= '0;
            bidx       <= '0;
            asm_r      <= '0;
            wc         <= '0;
            err_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        clr        <= '0;
                        from_start <= 1'b1;
                        wc         <= '0;
                        err_r      <= 1'b0;
                    end
                end
                CLEAR: clr <= clr + 6'd1;
                LEN: begin
                    if (xfer) begin
                        // Length 0 encodes a full 64-word load.
                        len  <= (byte_in[5:0] == 6'd0) ? 7'd64 : {1'b0, byte_in[5:0]};
                        wptr <= '0;
                        bidx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        asm_r <= asm_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= csum ^ byte_in;
`endif
                        if (word_last) begin
                            wptr <= wptr + 6'd1;
                            wc   <= wc + 7'd1;
                            bidx <= '0;
                        end else begin
                            bidx <= bidx + BW'(1);
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer && (byte_in != csum)) err_r <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
